// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for the EX stage.
// Multiplication is done as a shift-add over operand magnitudes. Division is
// done as a restoring divide over operand magnitudes. Signs are fixed up in
// FIN. Divide-by-zero and signed overflow skip the iterations and go straight
// to FIN. Result is valid in the FIN cycle, while Done is high.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   hi_q, hi_d;         // product high half / partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;         // multiplier+product low half / quotient
  logic               qneg_q, qneg_d;     // negate product or quotient
  logic               rneg_q, rneg_d;     // negate remainder
  logic               special_q, special_d;
  logic [WIDTH-1:0]   result_q, result_d;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    cond_neg = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    cond_neg2 = neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Operand decode used on acceptance
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;

  // Decode signedness, magnitudes and the fast-path cases from the raw request
  always_comb begin
    a_signed    = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
    b_signed    = Funct3[2] ? ~Funct3[0] : ~Funct3[1];
    a_neg       = a_signed & SrcA[WIDTH-1];
    b_neg       = b_signed & SrcB[WIDTH-1];
    a_mag       = cond_neg(SrcA, a_neg);
    b_mag       = cond_neg(SrcB, b_neg);
    div_zero    = Funct3[2] & (SrcB == '0);
    div_ovf     = Funct3[2] & ~Funct3[0] & (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcB == '1);
    special     = div_zero | div_ovf;
    if (div_zero) special_res = Funct3[1] ? SrcA : '1;
    else          special_res = Funct3[1] ? '0 : SrcA;
  end

  // One iteration step for each algorithm
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     dshift;
  logic [WIDTH-1:0]   dsub;
  logic               dge;
  logic [2*WIDTH-1:0] div_next;

  // Shift-add multiply step and restoring divide step
  always_comb begin
    msum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {msum, lo_q[WIDTH-1:1]};
    dshift   = {hi_q, lo_q[WIDTH-1]};
    dge      = dshift >= {1'b0, opnd_q};
    dsub     = dshift[WIDTH-1:0] - opnd_q;
    div_next = dge ? {dsub, lo_q[WIDTH-2:0], 1'b1}
                   : {dshift[WIDTH-1:0], lo_q[WIDTH-2:0], 1'b0};
  end

  // Sign correction and result selection for the FIN cycle
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   fin_result;

  // Apply the latched sign flags and select the requested word
  always_comb begin
    prod_c = cond_neg2({hi_q, lo_q}, qneg_q);
    if (special_q)
      fin_result = lo_q;
    else if (op_q[2])
      fin_result = op_q[1] ? cond_neg(hi_q, rneg_q) : cond_neg(lo_q, qneg_q);
    else if (op_q[1:0] == 2'b00)
      fin_result = prod_c[WIDTH-1:0];
    else
      fin_result = prod_c[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath update for IDLE/CALC/FIN
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    special_d = special_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (Start && !Flush) begin
          op_d   = Funct3;
          cnt_d  = '0;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          hi_d   = '0;
          if (special) begin
            special_d = 1'b1;
            opnd_d    = '0;
            lo_d      = special_res;
            state_d   = S_FIN;
          end else begin
            special_d = 1'b0;
            opnd_d    = Funct3[2] ? b_mag : a_mag;
            lo_d      = Funct3[2] ? a_mag : b_mag;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          {hi_d, lo_d} = op_q[2] ? div_next : mul_next;
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!Flush) result_d = fin_result;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  assign Busy   = (state_q == S_CALC) || (state_q == S_FIN);
  assign Stall  = ((state_q == S_IDLE) && Start) || (state_q == S_CALC);
  assign Done   = (state_q == S_FIN) && !Flush;
  assign Result = Done ? fin_result : result_q;

endmodule
